rv32i_mc_ctrl: RTL

//  Multi-cycle control unit for the next-generation RV32I core. Sequences FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/rv32i_mc_ctrl.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with req/ack memories, trap and instret.
// Latency: ALU 4, BRANCH/JAL/JALR 3, FENCE 2, STORE 4, LOAD 5 cycles (+1 per memory wait cycle).
// Backpressure: imem_req/dmem_req held until ack; a req unacked for ACK_TIMEOUT cycles traps (cause 2).
// Ports: clk/areset_n (sync, active-low); IR fields opcode/funct3/funct7b5/funct12b0; ALU zero flag;
//        imem/dmem req/ack handshakes plus dmem_we; datapath strobes ir_we/rf_we/pc_we;
//        selects pc_sel/alu_src_a/alu_src_b/alu_op/wb_sel; trap/trap_cause status; instret counter.
module rv32i_mc_ctrl #(
    parameter int ACK_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                areset_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                funct12b0,
    input  logic                zero,
    input  logic                imem_ack,
    input  logic                dmem_ack,
    output logic                imem_req,
    output logic                ir_we,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                rf_we,
    output logic                pc_we,
    output logic [1:0]          pc_sel,
    output logic [1:0]          alu_src_a,
    output logic                alu_src_b,
    output logic [3:0]          alu_op,
    output logic [1:0]          wb_sel,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [RETIRE_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_ENV     = 2'd3;

    localparam int              CNT_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    state_t            state, state_next;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [1:0]        cause_next;
    logic              tmo_hit;
    logic              br_taken;
    logic              is_alu_cls;
    logic [3:0]        ex_op;
    logic [1:0]        ex_a;
    logic              ex_b;
    logic              unused_sys;

    // ECALL and EBREAK report the same cause, so instr[20] is not needed.
    assign unused_sys = funct12b0;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt, input logic is_reg);
        logic [3:0] op;
        case (f3)
            3'd0:    op = (alt && is_reg) ? 4'd1 : 4'd0;
            3'd1:    op = 4'd2;
            3'd2:    op = 4'd3;
            3'd3:    op = 4'd4;
            3'd4:    op = 4'd5;
            3'd5:    op = alt ? 4'd7 : 4'd6;
            3'd6:    op = 4'd8;
            default: op = 4'd9;
        endcase
        return op;
    endfunction

    // Expiry fires on the last allowed wait cycle; an ack in that cycle takes priority.
    assign tmo_hit    = (ACK_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    // BEQ/BGE/BGEU take on zero, their odd-funct3 partners on the inverse; signed/unsigned
    // compares produce zero when the SLT result is 0 (i.e. not less-than).
    assign br_taken   = (funct3[2] ? ~zero : zero) ^ funct3[0];
    assign is_alu_cls = (opcode == OP_REG) || (opcode == OP_IMM) ||
                        (opcode == OP_LUI) || (opcode == OP_AUIPC);

    // ALU operand/op selection per instruction class; reused in EXEC, MEM and WB so the
    // datapath sees stable inputs for as long as the result is consumed.
    always_comb begin
        ex_op = 4'd0;
        ex_a  = 2'd0;
        ex_b  = 1'b0;
        case (opcode)
            OP_REG:   ex_op = alu_from_f3(funct3, funct7b5, 1'b1);
            OP_IMM: begin
                ex_op = alu_from_f3(funct3, funct7b5, 1'b0);
                ex_b  = 1'b1;
            end
            OP_LUI: begin
                ex_a = 2'd2;
                ex_b = 1'b1;
            end
            OP_AUIPC: begin
                ex_a = 2'd1;
                ex_b = 1'b1;
            end
            OP_LOAD, OP_STORE, OP_JALR: ex_b = 1'b1;
            OP_BRANCH: ex_op = !funct3[2] ? 4'd1 : (!funct3[1] ? 4'd3 : 4'd4);
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        cause_next = trap_cause;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'd0;
        alu_src_a  = 2'd0;
        alu_src_b  = 1'b0;
        alu_op     = 4'd0;
        wb_sel     = 2'd0;
        case (state)
            S_IDLE: state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                    OP_LOAD, OP_STORE, OP_IMM, OP_REG: state_next = S_EXEC;
                    OP_FENCE: begin
                        pc_we      = 1'b1;
                        state_next = S_FETCH;
                    end
                    OP_SYSTEM: begin
                        state_next = S_TRAP;
                        // SYSTEM encodings with nonzero funct3 (CSR access) report as illegal.
                        cause_next = (funct3 == 3'd0) ? CAUSE_ENV : CAUSE_ILLEGAL;
                    end
                    default: begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC: begin
                alu_op    = ex_op;
                alu_src_a = ex_a;
                alu_src_b = ex_b;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM;
                    OP_BRANCH: begin
                        pc_we      = 1'b1;
                        pc_sel     = br_taken ? 2'd1 : 2'd0;
                        state_next = S_FETCH;
                    end
                    OP_JAL, OP_JALR: begin
                        rf_we      = 1'b1;
                        wb_sel     = 2'd2;
                        pc_we      = 1'b1;
                        pc_sel     = (opcode == OP_JAL) ? 2'd1 : 2'd2;
                        state_next = S_FETCH;
                    end
                    default: state_next = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                dmem_we   = (opcode == OP_STORE);
                alu_op    = ex_op;
                alu_src_a = ex_a;
                alu_src_b = ex_b;
                if (dmem_ack) begin
                    if (opcode == OP_STORE) begin
                        pc_we      = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                wb_sel     = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
                state_next = S_FETCH;
                // No result register: ALU controls stay up while its output is written back.
                if (is_alu_cls) begin
                    alu_op    = ex_op;
                    alu_src_a = ex_a;
                    alu_src_b = ex_b;
                end
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!areset_n) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
            instret    <= '0;
        end else begin
            state <= state_next;
            // Counts only while a request stays pending in the same state; any transition
            // (including into FETCH/MEM) restarts it from zero.
            if ((state_next == state) && (imem_req || dmem_req))
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            else
                tmo_cnt <= '0;
            if ((state_next == S_TRAP) && (state != S_TRAP)) begin
                trap       <= 1'b1;
                trap_cause <= cause_next;
            end
            if (pc_we)
                instret <= instret + RETIRE_W'(1);
        end
    end

endmodule
